// File: rtl/sd_spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first) for the SD slot on the picorv32 native bus.
// Optional transfer-done interrupt is built when SD_SPI_IRQ_EN is defined.
module sd_spi_master #(
    parameter int unsigned DIV_RESET = 62,
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
`ifdef SD_SPI_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    localparam logic [DIV_WIDTH-1:0] PhaseOne = 1;

    state_e               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           rx_q, rx_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0] phase_q, phase_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 ovr_q, ovr_d;
    logic                 ready_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;

    logic       accept, is_wr, wr_data, wr_ctrl, wr_div, data_acc, done_evt, busy_d;
    logic [1:0] sel;
    logic       unused_bits;

    assign unused_bits = ^{mem_addr, mem_wdata};

    always_comb begin
        accept   = mem_valid && !ready_q;
        is_wr    = |mem_wstrb;
        sel      = mem_addr[3:2];
        wr_data  = accept && is_wr && (sel == 2'd0);
        wr_ctrl  = accept && is_wr && (sel == 2'd1);
        wr_div   = accept && is_wr && (sel == 2'd2);
        data_acc = accept && (sel == 2'd0);

        state_d   = state_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        div_d     = div_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        ovr_d     = ovr_q;
        done_evt  = 1'b0;

        if (wr_ctrl) begin
            cs_n_d = mem_wdata[0];
            if (mem_wdata[1]) ovr_d = 1'b0;
        end
        if (wr_div) div_d = mem_wdata[DIV_WIDTH-1:0];
        if (wr_data && state_q != StIdle) ovr_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (wr_data) begin
                    shift_d   = mem_wdata[7:0];
                    mosi_d    = mem_wdata[7];
                    bit_cnt_d = 3'd0;
                    phase_d   = div_q;
                    state_d   = StLow;
                end
            end
            StLow: begin
                if (phase_q == '0) begin
                    sck_d   = 1'b1;
                    phase_d = div_q;
                    state_d = StHigh;
                end else begin
                    phase_d = phase_q - PhaseOne;
                end
            end
            StHigh: begin
                if (phase_q == '0) begin
                    // MISO is sampled on the same edge that drops SCK
                    shift_d = {shift_q[6:0], miso};
                    sck_d   = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        rx_d     = {shift_q[6:0], miso};
                        mosi_d   = 1'b1;
                        state_d  = StIdle;
                        done_evt = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        mosi_d    = shift_q[6];
                        phase_d   = div_q;
                        state_d   = StLow;
                    end
                end else begin
                    phase_d = phase_q - PhaseOne;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef SD_SPI_IRQ_EN
        irq_en_d = wr_ctrl ? mem_wdata[2] : irq_en_q;
        done_d   = done_q;
        if (data_acc || (wr_ctrl && mem_wdata[4])) done_d = 1'b0;
        if (done_evt) done_d = 1'b1;
`else
        irq_en_d = 1'b0;
        done_d   = 1'b0;
`endif

        // Reads report post-edge state so a read on the falling-busy edge sees the result
        busy_d  = (state_d != StIdle);
        rdata_d = 32'd0;
        if (accept && !is_wr) begin
            unique case (sel)
                2'd0:    rdata_d = {24'd0, rx_d};
                2'd1:    rdata_d = {27'd0, done_d, irq_en_d, ovr_d, busy_d, cs_n_q};
                2'd2:    rdata_d = {{(32-DIV_WIDTH){1'b0}}, div_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= 8'd0;
            rx_q      <= 8'd0;
            bit_cnt_q <= 3'd0;
            phase_q   <= '0;
            div_q     <= DIV_RESET[DIV_WIDTH-1:0];
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            ovr_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            ovr_q     <= ovr_d;
            ready_q   <= accept;
            rdata_q   <= rdata_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
`ifdef SD_SPI_IRQ_EN
    assign irq       = done_q & irq_en_q;
`endif

endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- Memory-mapped hardware SPI master for the SD card slot. Replaces CPU bit-banging of SCK/MOSI/CS_n with a byte-level shift engine and a programmable clock divider.
- Sits on the picorv32 native memory bus at the SD peripheral window. mem_valid arrives pre-qualified by the top-level address decoder.
- Drives the physical SD pins directly in SPI mode 0, MSB first.

Parameters:
- DIV_RESET, 62: reset value of the DIV register. SCK half-period = (DIV+1) clk cycles, so 62 gives ~397 kHz at 50 MHz for SD init.
- DIV_WIDTH, 8: width of the DIV register and the phase counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  bus request, pre-decoded for this block
- mem_addr  in  32  byte address; only [3:2] decoded
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; any bit set = write, all zero = read
- mem_ready  out  1  one-cycle acknowledge
- mem_rdata  out  32  read data, valid while mem_ready=1
- sck  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  1  card select, active low
- irq  out  1  transfer-done interrupt; present only with SD_SPI_IRQ_EN

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, sck=0, mosi=1, cs_n=1, busy=0, ovr=0, rx=0x00, DIV=DIV_RESET, state=IDLE.
- Bus handshake:
  - A request is accepted when mem_valid=1 and mem_ready=0. mem_ready pulses high for exactly one cycle on the next edge.
  - Back-to-back acknowledges never occur. Every access completes in 1 cycle, including while busy.
- Register map (addr[3:2]):
  - 0: DATA. Write [7:0] loads the TX byte and starts a transfer. Read returns {24'b0, rx}.
  - 1: CTRL/STATUS.
    - Write: bit0 → cs_n. bit1=1 clears ovr. bit2 → irq_en (with macro only).
    - Read: bit0 cs_n, bit1 busy, bit2 ovr, bit3 irq_en (0 without macro). Other bits 0.
  - 2: DIV. Write [DIV_WIDTH-1:0]; read back zero-extended.
  - 3: reserved. Reads 0; writes ignored.
- Write to DATA while busy: data ignored, transfer undisturbed, ovr set (sticky). mem_ready still pulses.
- cs_n writes take effect on the acknowledge edge, even while busy. Correct framing is software's job.
- DIV writes while busy are accepted. The new value is used from the next phase-counter reload.
- State machine IDLE → LOW → HIGH → (LOW | IDLE). Counters: 3-bit bit_cnt, DIV_WIDTH-bit phase counter.
  - IDLE + DATA write: shift←wdata[7:0], mosi←wdata[7], bit_cnt←0, phase←DIV, busy←1, go LOW. sck stays 0.
  - LOW: phase decrements each cycle. At phase=0: sck←1, phase←DIV, go HIGH.
  - HIGH: phase decrements. At phase=0: sample miso into shift[0] while shifting left, sck←0.
    - If bit_cnt=7: rx←{shift[6:0],miso}, busy←0, mosi←1, go IDLE, done event.
    - Else: bit_cnt++, mosi←next bit (shift[6] before the shift), phase←DIV, go LOW.
- Timing: MISO is sampled on the clk edge that drives sck 1→0. Full margin for a card updating MISO on the falling edge.
- Transfer length from the acknowledge edge to busy falling is exactly 16*(DIV+1) clk cycles.
- DIV=0 is legal: SCK = clk/2.
- A STATUS read in the same cycle busy falls returns busy=0. DATA then already holds the new rx.
- rx holds its value until the next transfer completes.
- Reset mid-transfer: all state returns to reset values immediately; a partial byte is discarded and rx=0x00.

Optional Feature:
- Macro: SD_SPI_IRQ_EN.
- Defined:
  - irq port exists; irq_en is a CTRL bit2 flop, reset 0.
  - The done event sets a sticky done flag, readable as STATUS bit4.
  - irq = done & irq_en.
  - done clears on any DATA access (read or write) or a CTRL write with bit4=1.
- Undefined: no irq port, no done/irq_en flops. STATUS bits 3 and 4 read 0; CTRL bit2 is ignored.

Test Plan:
- Reset, then read STATUS → 0x00000001; read DIV → 62; sck=0, mosi=1, cs_n=1.
- DIV=0, CTRL=0 (cs_n=0), write DATA=0xA5 with miso looped to mosi.
  - Expected: mosi sequence 1,0,1,0,0,1,0,1 on rising sck; 8 sck pulses, each 1 clk high / 1 clk low.
  - busy clears exactly 16 cycles after the ack; DATA read → 0x000000A5.
- DIV=3, miso tied 0, write DATA=0xFF.
  - Expected: sck half-period 4 clk; busy high for exactly 64 cycles; rx=0x00; mosi returns to 1 after the transfer.
- DIV=3, during a transfer write DATA=0x12 → transfer bits unchanged; STATUS bit2=1. CTRL write bit1=1 → STATUS bit2=0.
- DIV=0, assert reset at bit 4 of a 0xC3 transfer → next cycle sck=0, mosi=1, cs_n=1, busy=0, rx=0x00.
- (SD_SPI_IRQ_EN) CTRL=0x4, DATA=0x3C → irq rises on the cycle busy falls; DATA read → irq=0 the cycle after the ack.
